// File: rtl/vga_native_arbiter.sv
// vga_native_arbiter: round-robin arbiter sharing one native register-bank port between two requesters.
// Define VGA_NATIVE_ARB_FIXED_PRIO_EN for strict m0 priority instead of round-robin.
module vga_native_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              write_en_o,
    output logic [ADDR_W-1:0] addr_write_o,
    output logic [DATA_W-1:0] data2native_o,
    output logic              read_en_sync_o,
    output logic [ADDR_W-1:0] addr_read_o,
    input  logic [DATA_W-1:0] data2axil_i
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
    logic [1:0]        state_q, state_d, gnt_q, gnt_d, rv_q, rv_d;
    logic              sel_q, sel_d, last_q, last_d, we_q, we_d, re_q, re_d;
    logic              pick, p_we;
    logic [ADDR_W-1:0] p_addr, wa_q, wa_d, ra_q, ra_d;
    logic [DATA_W-1:0] p_wdata, wd_q, wd_d, rd0_q, rd0_d, rd1_q, rd1_d;
`ifdef VGA_NATIVE_ARB_FIXED_PRIO_EN
    assign pick = ~m0_req_i;
`else
    // last_q=1 means m1 was served last, so m0 wins the next contention
    assign pick = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
`endif
    assign p_we    = pick ? m1_we_i : m0_we_i;
    assign p_addr  = pick ? m1_addr_i : m0_addr_i;
    assign p_wdata = pick ? m1_wdata_i : m0_wdata_i;
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gnt_d   = '0;
        rv_d    = '0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        wa_d    = '0;
        wd_d    = '0;
        ra_d    = '0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: if (m0_req_i | m1_req_i) begin
                state_d = ISSUE;
                sel_d   = pick;
                last_d  = pick;
                gnt_d   = pick ? 2'b10 : 2'b01;
                we_d    = p_we;
                re_d    = ~p_we;
                wa_d    = p_we ? p_addr : '0;
                wd_d    = p_we ? p_wdata : '0;
                ra_d    = p_we ? '0 : p_addr;
            end
            ISSUE: state_d = re_q ? RESP : IDLE;
            RESP: begin
                state_d = IDLE;
                rv_d    = sel_q ? 2'b10 : 2'b01;
                rd0_d   = sel_q ? rd0_q : data2axil_i;
                rd1_d   = sel_q ? data2axil_i : rd1_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= '0;
            rv_q    <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            ra_q    <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            rv_q    <= rv_d;
            we_q    <= we_d;
            re_q    <= re_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            ra_q    <= ra_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end
    assign m0_gnt_o       = gnt_q[0];
    assign m1_gnt_o       = gnt_q[1];
    assign m0_rvalid_o    = rv_q[0];
    assign m1_rvalid_o    = rv_q[1];
    assign m0_rdata_o     = rd0_q;
    assign m1_rdata_o     = rd1_q;
    assign write_en_o     = we_q;
    assign addr_write_o   = wa_q;
    assign data2native_o  = wd_q;
    assign read_en_sync_o = re_q;
    assign addr_read_o    = ra_q;
endmodule

// File: tb/tb_vga_native_arbiter.sv
// tb_vga_native_arbiter: directed and random checks of vga_native_arbiter against a cycle-schedule model and bank.
module tb_vga_native_arbiter;
    localparam int NC = 4096;
`ifdef VGA_NATIVE_ARB_FIXED_PRIO_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, pre = 1'b1;
    logic        r0 = 0, we0 = 0, r1 = 0, we1 = 0, b0 = 0, b1 = 0;
    logic [7:0]  a0 = 0, a1 = 0;
    logic [31:0] d0 = 0, d1 = 0;
    logic        g0, g1, v0, v1, wen, ren;
    logic [7:0]  wa, ra;
    logic [31:0] rd0, rd1, wd, d2a;
    logic [31:0] bank [256];
    logic [31:0] mem [256];
    logic        e_g0 [NC], e_g1 [NC], e_we [NC], e_re [NC], e_v0 [NC], e_v1 [NC], e_clr [NC];
    logic [7:0]  e_wa [NC], e_ra [NC];
    logic [31:0] e_wd [NC], e_vd [NC];
    logic [31:0] rd0m = 0, rd1m = 0;
    int          cyc = 0, free_at = 0, nchk = 0, nerr = 0;
    logic        lg = 1'b1;

    vga_native_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(r0), .m0_we_i(we0), .m0_addr_i(a0), .m0_wdata_i(d0),
        .m0_gnt_o(g0), .m0_rvalid_o(v0), .m0_rdata_o(rd0),
        .m1_req_i(r1), .m1_we_i(we1), .m1_addr_i(a1), .m1_wdata_i(d1),
        .m1_gnt_o(g1), .m1_rvalid_o(v1), .m1_rdata_o(rd1),
        .write_en_o(wen), .addr_write_o(wa), .data2native_o(wd),
        .read_en_sync_o(ren), .addr_read_o(ra), .data2axil_i(d2a)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'h12345678 : ((32'(i) * 32'h01010101) ^ 32'h5A5A0000);
    endfunction

    // bank: write port, synchronous read with one cycle latency, junk when not reading
    always @(posedge clk) begin
        if (pre) for (int i = 0; i < 256; i++) bank[i] <= init_val(i);
        else if (wen) bank[wa] <= wd;
        d2a <= ren ? bank[ra] : $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic clr(input int j);
        e_g0[j] = 0; e_g1[j] = 0; e_we[j] = 0; e_re[j] = 0; e_v0[j] = 0; e_v1[j] = 0;
        e_wa[j] = 0; e_ra[j] = 0; e_wd[j] = 0; e_vd[j] = 0;
    endtask

    // schedule: a request seen in a free cycle c is issued at c+1, read data returns at c+3
    task automatic predict();
        logic w, wr;
        logic [7:0] ad;
        logic [31:0] da;
        if (rst) begin
            for (int j = 1; j <= 3; j++) clr(cyc + j);
            e_clr[cyc+1] = 1;
            lg = 1'b1;
            free_at = cyc + 1;
            return;
        end
        if (cyc < free_at || !(r0 || r1)) return;
        w  = (r0 && r1) ? (FIX ? 1'b0 : !lg) : r1;
        lg = w;
        wr = w ? we1 : we0;
        ad = w ? a1 : a0;
        da = w ? d1 : d0;
        e_g0[cyc+1] = !w;
        e_g1[cyc+1] = w;
        if (wr) begin
            e_we[cyc+1] = 1; e_wa[cyc+1] = ad; e_wd[cyc+1] = da;
            mem[ad] = da;
            free_at = cyc + 2;
        end else begin
            e_re[cyc+1] = 1; e_ra[cyc+1] = ad;
            if (w) e_v1[cyc+3] = 1; else e_v0[cyc+3] = 1;
            e_vd[cyc+3] = mem[ad];
            free_at = cyc + 3;
        end
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= NC - 4) begin
            $display("FAIL budget cyc=%0d", cyc);
            $fatal(1);
        end
        if (e_clr[cyc]) begin rd0m = 0; rd1m = 0; end
        if (e_v0[cyc]) rd0m = e_vd[cyc];
        if (e_v1[cyc]) rd1m = e_vd[cyc];
        chk("m0_gnt", g0, e_g0[cyc]);
        chk("m1_gnt", g1, e_g1[cyc]);
        chk("write_en", wen, e_we[cyc]);
        chk("addr_write", wa, e_wa[cyc]);
        chk("data2native", wd, e_wd[cyc]);
        chk("read_en", ren, e_re[cyc]);
        chk("addr_read", ra, e_ra[cyc]);
        chk("m0_rvalid", v0, e_v0[cyc]);
        chk("m1_rvalid", v1, e_v1[cyc]);
        chk("m0_rdata", rd0, rd0m);
        chk("m1_rdata", rd1, rd1m);
        chk("exclusive", 32'((g0 & g1) | (wen & ren)), 0);
        if (g0) begin r0 = 0; b0 = ~we0; end
        if (g1) begin r1 = 0; b1 = ~we1; end
        if (v0) b0 = 0;
        if (v1) b1 = 0;
    endtask

    task automatic req0(input logic w, input logic [7:0] a, input logic [31:0] d);
        r0 = 1; we0 = w; a0 = a; d0 = d;
    endtask

    task automatic req1(input logic w, input logic [7:0] a, input logic [31:0] d);
        r1 = 1; we1 = w; a1 = a; d1 = d;
    endtask

    task automatic do_reset();
        rst = 1; r0 = 0; r1 = 0; b0 = 0; b1 = 0;
        tick();
        rst = 0;
    endtask

    initial begin
        int order [4];
        int ng, ntx;
        for (int j = 0; j < NC; j++) begin clr(j); e_clr[j] = 0; end
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        tick();
        tick();
        pre = 0;
        rst = 0;
        req0(1, 8'h04, 32'hDEADBEEF);
        tick();
        chk("wr_gnt", g0, 1);
        chk("wr_en", wen, 1);
        chk("wr_addr", wa, 8'h04);
        chk("wr_data", wd, 32'hDEADBEEF);
        chk("wr_m1gnt", g1, 0);
        tick();
        req1(0, 8'h10, 0);
        tick();
        chk("rd_en", ren, 1);
        chk("rd_addr", ra, 8'h10);
        tick();
        tick();
        chk("rd_rvalid", v1, 1);
        chk("rd_data", rd1, 32'h12345678);
        chk("rd_m0rvalid", v0, 0);
        req0(1, 8'h08, 32'hA5A5A5A5);
        req1(0, 8'h08, 0);
        tick();
        chk("cont_first", g0, 1);
        repeat (4) tick();
        chk("cont_rvalid", v1, 1);
        chk("cont_data", rd1, 32'hA5A5A5A5);
        do_reset();
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            if (!r0) req0(1, 8'($urandom_range(32, 255)), $urandom);
            if (!r1) req1(1, 8'($urandom_range(32, 255)), $urandom);
            tick();
            if (ng < 4 && (g0 || g1)) begin order[ng] = int'(g1); ng++; end
        end
        chk("alt_count", ng, 4);
        for (int i = 0; i < 4; i++) chk("alt_order", order[i], FIX ? 0 : i % 2);
        r0 = 0; r1 = 0;
        tick();
        tick();
        req0(0, 8'h04, 0);
        repeat (3) tick();
        chk("rd04_rvalid", v0, 1);
        chk("rd04_data", rd0, 32'hDEADBEEF);
        req0(0, 8'h10, 0);
        tick();
        tick();
        do_reset();
        chk("rst_rvalid", v0, 0);
        chk("rst_rdata", rd0, 0);
        chk("rst_re", ren, 0);
        tick();
        chk("rst_norvalid", v0, 0);
        req0(0, 8'h10, 0);
        repeat (3) tick();
        chk("rd2_rvalid", v0, 1);
        chk("rd2_data", rd0, 32'h12345678);
        ntx = 0;
        while (ntx < 200) begin
            if (!r0 && !b0 && $urandom_range(0, 1) == 1) req0(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            if (!r1 && !b1 && $urandom_range(0, 1) == 1) req1(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            tick();
            ntx += int'(g0) + int'(g1);
        end
        r0 = 0; r1 = 0;
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/vga_native_arbiter.md
Name: vga_native_arbiter

Overview:
- Round-robin arbiter sharing one native register-bank port between two requesters.
- m0 is the native side of the AXI-Lite slave FSM (host CPU path). m1 is an internal requester, e.g. the VGA timing/config loader.
- Serialises single-beat reads and writes onto the bank's write port and synchronous-read port, then routes read data back to the requester that issued the read.

Parameters:
- ADDR_W, 8, native (word) address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 transaction request.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  word address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  one-cycle grant pulse; the transaction is issued that cycle.
- m0_rvalid  out  1  one-cycle read-data-valid pulse.
- m0_rdata  out  DATA_W  read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for requester 1.
- write_en  out  1  bank write strobe.
- addr_write  out  ADDR_W  bank write address.
- data2native  out  DATA_W  bank write data.
- read_en_sync  out  1  bank read strobe.
- addr_read  out  ADDR_W  bank read address.
- data2axil  in  DATA_W  bank read data; valid exactly 1 cycle after read_en_sync.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE, last_grant=1 (m0 wins the first contention).
  - All gnt, rvalid, write_en and read_en_sync = 0.
  - All addr/data outputs and m*_rdata = 0.
- States: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - If any req=1, choose a winner, capture its we/addr/wdata and latch sel; go to ISSUE.
  - If both requests are asserted, the winner is the requester other than last_grant. With one request, that requester wins.
  - last_grant is updated when the winner is chosen.
- ISSUE (one cycle):
  - gnt[sel]=1.
  - Write: write_en=1, addr_write=captured addr, data2native=captured data; next state IDLE.
  - Read: read_en_sync=1, addr_read=captured addr; next state RESP.
  - Requests are not sampled in ISSUE.
- RESP (one cycle):
  - m[sel]_rdata <= data2axil; m[sel]_rvalid=1 in the following cycle, while the FSM is back in IDLE.
  - rvalid and rdata update in the same edge.
  - m*_rdata holds its value until that requester's next read.
- Latency:
  - req seen in cycle N → gnt and bank strobe in N+1.
  - Read rvalid in N+3.
  - Peak throughput: one write per 2 cycles, one read per 3 cycles.
- Requester rule: hold req and payload stable until gnt is sampled high, then drop req the next cycle. A requester may assert req again in the cycle its rvalid arrives.
- Strobes and gnt are never asserted for both requesters in the same cycle. write_en and read_en_sync are never both 1.
- addr_write, data2native and addr_read are 0 whenever their strobe is 0.
- Reset mid-read (in ISSUE or RESP): the transaction is dropped, no rvalid is produced, and m*_rdata is cleared.
- Back-to-back same requester: if only m0 requests continuously, m0 is served every free IDLE slot; no idle cycle is inserted beyond the FSM itself.

Optional Feature:
- Macro VGA_NATIVE_ARB_FIXED_PRIO_EN.
- Defined: strict priority; m0 always wins contention; last_grant is unused and m1 can starve.
- Undefined (default): round-robin as above.
- Latency and handshake are unchanged in both cases.

Test Plan:
- Reset, then m0 write addr 0x04 data 0xDEADBEEF in cycle N → m0_gnt and write_en at N+1, addr_write=0x04, data2native=0xDEADBEEF; m1_gnt stays 0.
- Bank model preloaded addr 0x10=0x12345678; m1 reads 0x10 → read_en_sync at N+1 with addr_read=0x10; m1_rvalid=1 and m1_rdata=0x12345678 at N+3; m0_rvalid stays 0.
- Both requesters request continuously after reset: grants alternate m0,m1,m0,m1 over 4 transactions. With FIXED_PRIO_EN, m0 receives all grants while it requests.
- m0 writes 0x08=0xA5A5A5A5 while m1 simultaneously reads 0x08 (m1 won last) → m0 write issues first, then the m1 read returns 0xA5A5A5A5.
- rst asserted in the RESP cycle of an m0 read → no m0_rvalid ever; all outputs 0 the cycle after; a subsequent m0 read completes normally.
- Random 200 mixed transactions from both requesters with a scoreboard and bank model → every read returns the last written value; strobe exclusivity and one-gnt-per-req asserted every cycle.
